// File: rtl/ws2811_serial_decoder_if.sv
// Signal bundle between the WS2811 loopback decoder and whoever drives the line
// and consumes decoded pixels / shadow-buffer reads.
interface ws2811_serial_decoder_if;
  logic        serial_in;
  logic [3:0]  rd_index;
  logic [23:0] rd_data;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  led_count;
  logic [2:0]  frame_error;
  logic        stuck_error;

  modport master (
    output serial_in, rd_index,
    input  rd_data, pixel_valid, pixel_data, pixel_index,
           frame_done, led_count, frame_error, stuck_error
  );

  modport slave (
    input  serial_in, rd_index,
    output rd_data, pixel_valid, pixel_data, pixel_index,
           frame_done, led_count, frame_error, stuck_error
  );
endinterface

// File: rtl/ws2811_serial_decoder.sv
// Decodes a WS2811 single-wire stream into 24-bit words, counts LEDs per frame
// and keeps the last error-free frame in a readable shadow buffer.
module ws2811_serial_decoder #(
  parameter int BIT_THRESH   = 30,
  parameter int MIN_HIGH     = 5,
  parameter int MAX_HIGH     = 50,
  parameter int RESET_CYCLES = 2500,
  parameter int MAX_LEDS     = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  ws2811_serial_decoder_if.slave   bus
);

  localparam logic [7:0]  BIT_THRESH_W = 8'(BIT_THRESH);
  localparam logic [7:0]  MIN_HIGH_W   = 8'(MIN_HIGH);
  localparam logic [7:0]  MAX_HIGH_W   = 8'(MAX_HIGH);
  localparam logic [11:0] RESET_W      = 12'(RESET_CYCLES);
  localparam logic [7:0]  MAX_LEDS_W   = 8'(MAX_LEDS);

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic        sync1_r;
  logic        s_r;
  logic        s_prev_r;
  logic        rise_s;
  logic        fall_s;

  logic [7:0]  high_cnt_r;
  logic [11:0] low_cnt_r;
  logic        low_hit_s;
  logic        count_low_s;

  logic        shift_en_s;
  logic        bit_val_s;
  logic        glitch_s;
  logic        stuck_s;
  logic        frame_end_s;

  logic [23:0] shift_r;
  logic [23:0] shift_nxt_s;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  word_cnt_r;
  logic        glitch_r;
  logic        ovf_r;
  logic [2:0]  err_s;

  logic [23:0] work_r   [MAX_LEDS];
  logic [23:0] shadow_r [MAX_LEDS];

  logic [23:0] rd_data_r;
  logic        pixel_valid_r;
  logic [23:0] pixel_data_r;
  logic [7:0]  pixel_index_r;
  logic        frame_done_r;
  logic [7:0]  led_count_r;
  logic [2:0]  frame_error_r;
  logic        stuck_error_r;

  assign rise_s      = s_r & ~s_prev_r;
  assign fall_s      = ~s_r & s_prev_r;
  assign low_hit_s   = (low_cnt_r >= (RESET_W - 12'd1));
  assign count_low_s = ~s_r & ((state_r == WAIT_GAP) | (state_r == LOW));
  assign shift_nxt_s = {shift_r[22:0], bit_val_s};
  assign err_s       = {ovf_r, (bit_cnt_r != 5'd0), glitch_r};

  // Two-flop synchroniser plus the delayed copy used for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      s_r      <= 1'b0;
      s_prev_r <= 1'b0;
    end else begin
      sync1_r  <= bus.serial_in;
      s_r      <= sync1_r;
      s_prev_r <= s_r;
    end
  end

  // Pulse-width counters; both saturate so a dead line cannot wrap them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_cnt_r <= 8'd0;
      low_cnt_r  <= 12'd0;
    end else begin
      if ((state_r == HIGH) && s_r) begin
        high_cnt_r <= (high_cnt_r == 8'hFF) ? 8'hFF : high_cnt_r + 8'd1;
      end else begin
        high_cnt_r <= 8'd0;
      end
      if (count_low_s) begin
        low_cnt_r <= (low_cnt_r >= RESET_W) ? RESET_W : low_cnt_r + 12'd1;
      end else begin
        low_cnt_r <= 12'd0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= WAIT_GAP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a rising edge in LOW beats a simultaneous frame end.
  always_comb begin
    state_nxt_s = state_r;
    shift_en_s  = 1'b0;
    bit_val_s   = 1'b0;
    glitch_s    = 1'b0;
    stuck_s     = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      WAIT_GAP: begin
        if (!s_r && low_hit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_GAP;
        end
      end
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HIGH: begin
        if (high_cnt_r > MAX_HIGH_W) begin
          stuck_s     = 1'b1;
          state_nxt_s = WAIT_GAP;
        end else if (fall_s) begin
          state_nxt_s = LOW;
          if (high_cnt_r < MIN_HIGH_W) begin
            glitch_s = 1'b1;
          end else begin
            shift_en_s = 1'b1;
            bit_val_s  = (high_cnt_r >= BIT_THRESH_W);
          end
        end else begin
          state_nxt_s = HIGH;
        end
      end
      LOW: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else if (low_hit_s) begin
          frame_end_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOW;
        end
      end
      default: begin
        state_nxt_s = WAIT_GAP;
      end
    endcase
  end

  // Word assembly, frame accounting and shadow-buffer commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_r       <= 24'd0;
      bit_cnt_r     <= 5'd0;
      word_cnt_r    <= 8'd0;
      glitch_r      <= 1'b0;
      ovf_r         <= 1'b0;
      pixel_valid_r <= 1'b0;
      pixel_data_r  <= 24'd0;
      pixel_index_r <= 8'd0;
      frame_done_r  <= 1'b0;
      led_count_r   <= 8'd0;
      frame_error_r <= 3'd0;
      stuck_error_r <= 1'b0;
      for (int i = 0; i < MAX_LEDS; i++) begin
        work_r[i]   <= 24'd0;
        shadow_r[i] <= 24'd0;
      end
    end else begin
      pixel_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      if (stuck_s) begin
        stuck_error_r <= 1'b1;
        shift_r       <= 24'd0;
        bit_cnt_r     <= 5'd0;
        word_cnt_r    <= 8'd0;
        glitch_r      <= 1'b0;
        ovf_r         <= 1'b0;
      end else if (frame_end_s) begin
        if ((word_cnt_r != 8'd0) || (bit_cnt_r != 5'd0)) begin
          frame_done_r  <= 1'b1;
          led_count_r   <= word_cnt_r;
          frame_error_r <= err_s;
          if (err_s == 3'd0) begin
            for (int i = 0; i < MAX_LEDS; i++) begin
              shadow_r[i] <= work_r[i];
            end
          end
        end
        shift_r    <= 24'd0;
        bit_cnt_r  <= 5'd0;
        word_cnt_r <= 8'd0;
        glitch_r   <= 1'b0;
        ovf_r      <= 1'b0;
      end else begin
        if (glitch_s) begin
          glitch_r <= 1'b1;
        end
        if (shift_en_s) begin
          shift_r <= shift_nxt_s;
          if (bit_cnt_r == 5'd23) begin
            pixel_valid_r <= 1'b1;
            pixel_data_r  <= shift_nxt_s;
            pixel_index_r <= word_cnt_r;
            if (word_cnt_r < MAX_LEDS_W) begin
              work_r[word_cnt_r[3:0]] <= shift_nxt_s;
            end else begin
              ovf_r <= 1'b1;
            end
            if (word_cnt_r != 8'hFF) begin
              word_cnt_r <= word_cnt_r + 8'd1;
            end
            bit_cnt_r <= 5'd0;
          end else begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_r <= 24'd0;
    end else if ({4'd0, bus.rd_index} < MAX_LEDS_W) begin
      rd_data_r <= shadow_r[bus.rd_index];
    end else begin
      rd_data_r <= 24'd0;
    end
  end

  assign bus.rd_data     = rd_data_r;
  assign bus.pixel_valid = pixel_valid_r;
  assign bus.pixel_data  = pixel_data_r;
  assign bus.pixel_index = pixel_index_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.led_count   = led_count_r;
  assign bus.frame_error = frame_error_r;
  assign bus.stuck_error = stuck_error_r;

endmodule
